// File: rtl/dct_quant_zigzag.sv
// dct_quant_zigzag
//   Takes one 4x4 block of signed Q11.4 DCT coefficients, quantizes every
//   coefficient by a per-block right shift (round half away from zero) and
//   streams the results one per cycle in zigzag order. Two block slots are
//   used ping-pong so a new block can be captured while the previous one is
//   still streaming out.
//
// Ports
//   clk       in   clock, rising edge
//   reset     in   synchronous, active-high
//   i_valid   in   input block valid
//   i_ready   out  a slot is free (registered state only)
//   i_data    in   256 bits, coeff[r][c] at i_data[255-64r-16c -: 16]
//   i_qshift  in   quantizer shift 0..7, sampled with i_data
//   o_valid   out  output coefficient valid
//   o_ready   in   downstream ready
//   o_coeff   out  quantized coefficient, signed, sign-extended to OUT_W
//   o_pos     out  raster position r*4+c of the current coefficient
//   o_zz      out  zigzag index 0..15
//   o_last    out  final coefficient of the block
//
// Interface FSM
//   state     | meaning
//   ----------+--------------------------------------------------
//   ST_EMPTY  | no slot holds a block, o_valid = 0
//   ST_STREAM | read slot full, write slot free, emitting
//   ST_FULL   | both slots full, emitting, i_ready = 0

module dct_quant_zigzag #(
  parameter int TRUNC_EOB = 0,
  parameter int OUT_W     = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_valid,
  output logic             i_ready,
  input  logic [255:0]     i_data,
  input  logic [2:0]       i_qshift,
  output logic             o_valid,
  input  logic             o_ready,
  output logic [OUT_W-1:0] o_coeff,
  output logic [3:0]       o_pos,
  output logic [3:0]       o_zz,
  output logic             o_last
);

  localparam logic [1:0] ST_EMPTY  = 2'd0;
  localparam logic [1:0] ST_STREAM = 2'd1;
  localparam logic [1:0] ST_FULL   = 2'd2;

  // zigzag index -> raster position
  function automatic logic [3:0] zz_to_raster(input logic [3:0] zz);
    logic [3:0] pos;
    case (zz)
      4'd0:    pos = 4'd0;
      4'd1:    pos = 4'd1;
      4'd2:    pos = 4'd4;
      4'd3:    pos = 4'd8;
      4'd4:    pos = 4'd5;
      4'd5:    pos = 4'd2;
      4'd6:    pos = 4'd3;
      4'd7:    pos = 4'd6;
      4'd8:    pos = 4'd9;
      4'd9:    pos = 4'd12;
      4'd10:   pos = 4'd13;
      4'd11:   pos = 4'd10;
      4'd12:   pos = 4'd7;
      4'd13:   pos = 4'd11;
      4'd14:   pos = 4'd14;
      default: pos = 4'd15;
    endcase
    return pos;
  endfunction

  // Magnitude is taken in 17 bits so that -32768 yields +32768. With
  // k = 4 + qshift the rounded magnitude never exceeds 2048, so 13 signed
  // bits hold every result without saturation.
  function automatic logic [12:0] quantize(input logic [15:0] c, input logic [2:0] qs);
    logic [16:0] mag;
    logic [16:0] sum;
    logic [4:0]  sh;
    logic [12:0] q;
    mag = c[15] ? (17'd0 - {c[15], c}) : {1'b0, c};
    sh  = 5'd4 + {2'b00, qs};
    sum = mag + (17'd1 << (sh - 5'd1));
    q   = 13'(sum >> sh);
    return c[15] ? (13'd0 - q) : q;
  endfunction

  logic [1:0]  state_q, state_d;
  logic [1:0]  full_q, full_d;
  logic        wr_ptr_q, wr_ptr_d;
  logic        rd_ptr_q, rd_ptr_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [12:0] coef_q [2][16];
  logic [3:0]  last_nz_q [2];

  logic [12:0] q_in [16];
  logic [3:0]  last_nz_in;
  logic [12:0] cur_q;
  logic        in_hs;
  logic        out_hs;
  logic        out_last_hs;

  always_comb begin
    for (int p = 0; p < 16; p++) begin
      q_in[p] = quantize(i_data[255-16*p -: 16], i_qshift);
    end
  end

  // Scanning in zigzag order leaves the highest nonzero zigzag index behind.
  always_comb begin
    last_nz_in = 4'd0;
    for (int z = 0; z < 16; z++) begin
      if (q_in[zz_to_raster(4'(z))] != 13'd0) begin
        last_nz_in = 4'(z);
      end
    end
  end

  assign i_ready     = ~full_q[wr_ptr_q];
  assign o_valid     = (state_q != ST_EMPTY);
  assign o_zz        = cnt_q;
  assign o_pos       = zz_to_raster(cnt_q);
  assign cur_q       = coef_q[rd_ptr_q][o_pos];
  assign o_coeff     = o_valid ? {{(OUT_W-12){cur_q[12]}}, cur_q[11:0]} : '0;

  always_comb begin
    o_last = 1'b0;
    if (o_valid) begin
      if (TRUNC_EOB != 0) begin
        o_last = (cnt_q == last_nz_q[rd_ptr_q]);
      end else begin
        o_last = (cnt_q == 4'd15);
      end
    end
  end

  assign in_hs       = i_valid & i_ready;
  assign out_hs      = o_valid & o_ready;
  assign out_last_hs = out_hs & o_last;

  // A capture always targets the free slot and a last handshake always
  // targets the full one, so both updates can land on the same edge.
  always_comb begin
    full_d   = full_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (in_hs) begin
      full_d[wr_ptr_q] = 1'b1;
      wr_ptr_d         = ~wr_ptr_q;
    end
    if (out_last_hs) begin
      full_d[rd_ptr_q] = 1'b0;
      rd_ptr_d         = ~rd_ptr_q;
      cnt_d            = 4'd0;
    end else if (out_hs) begin
      cnt_d = cnt_q + 4'd1;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_EMPTY: begin
        if (in_hs) state_d = ST_STREAM;
      end
      ST_STREAM: begin
        if (in_hs && !out_last_hs) begin
          state_d = ST_FULL;
        end else if (out_last_hs && !in_hs) begin
          state_d = ST_EMPTY;
        end
      end
      ST_FULL: begin
        if (out_last_hs) state_d = ST_STREAM;
      end
      default: state_d = ST_EMPTY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_EMPTY;
      full_q   <= 2'b00;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      cnt_q    <= 4'd0;
    end else begin
      state_q  <= state_d;
      full_q   <= full_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  // Slot contents need no reset: they are only read while the slot is full.
  always_ff @(posedge clk) begin
    if (in_hs) begin
      for (int p = 0; p < 16; p++) begin
        coef_q[wr_ptr_q][p] <= q_in[p];
      end
      last_nz_q[wr_ptr_q] <= last_nz_in;
    end
  end

endmodule

// File: tb/tb_dct_quant_zigzag.sv
module tb_dct_quant_zigzag;

  logic         clk = 1'b0;
  logic         reset;
  logic         i_valid_s [2];
  logic         i_ready_s [2];
  logic [255:0] i_data_s  [2];
  logic [2:0]   qs_s      [2];
  logic         o_valid_s [2];
  logic         o_ready_s [2];
  logic [15:0]  o_coeff_s [2];
  logic [3:0]   o_pos_s   [2];
  logic [3:0]   o_zz_s    [2];
  logic         o_last_s  [2];

  int rdy_mode [2] = '{1, 1};
  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  dct_quant_zigzag #(.TRUNC_EOB(0), .OUT_W(16)) dut0 (
    .clk(clk), .reset(reset),
    .i_valid(i_valid_s[0]), .i_ready(i_ready_s[0]), .i_data(i_data_s[0]), .i_qshift(qs_s[0]),
    .o_valid(o_valid_s[0]), .o_ready(o_ready_s[0]), .o_coeff(o_coeff_s[0]),
    .o_pos(o_pos_s[0]), .o_zz(o_zz_s[0]), .o_last(o_last_s[0]));

  dct_quant_zigzag #(.TRUNC_EOB(1), .OUT_W(16)) dut1 (
    .clk(clk), .reset(reset),
    .i_valid(i_valid_s[1]), .i_ready(i_ready_s[1]), .i_data(i_data_s[1]), .i_qshift(qs_s[1]),
    .o_valid(o_valid_s[1]), .o_ready(o_ready_s[1]), .o_coeff(o_coeff_s[1]),
    .o_pos(o_pos_s[1]), .o_zz(o_zz_s[1]), .o_last(o_last_s[1]));

  typedef struct {
    int coeff;
    int pos;
    int zz;
    bit last;
  } exp_t;

  typedef struct {
    logic [15:0] c;
    int          qs;
    int          q;
  } vec_t;

  exp_t sb0[$];
  exp_t sb1[$];
  int   ord [16];

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Zigzag order derived by walking anti-diagonals r+c = s; odd diagonals
  // run top-right to bottom-left, even ones the other way.
  function automatic void build_order();
    int idx = 0;
    for (int s = 0; s < 7; s++) begin
      for (int t = 0; t <= s; t++) begin
        int r = (s % 2 == 1) ? t : s - t;
        int c = s - r;
        if (r < 4 && c < 4) begin
          ord[idx] = r * 4 + c;
          idx++;
        end
      end
    end
  endfunction

  // Reference: value/2^qshift in real arithmetic, rounded half away from zero.
  function automatic void model(input logic [255:0] d, input int qs, input bit trunc,
                                output exp_t st [16], output int n);
    int q [16];
    int lastnz = 0;
    for (int p = 0; p < 16; p++) begin
      logic signed [15:0] c;
      real x;
      real scale = 16.0;
      c = d[255-16*p -: 16];
      for (int i = 0; i < qs; i++) scale = scale * 2.0;
      x = real'(c) / scale;
      if (x < 0.0) q[p] = -$rtoi($floor(-x + 0.5));
      else         q[p] =  $rtoi($floor( x + 0.5));
    end
    for (int z = 0; z < 16; z++) if (q[ord[z]] != 0) lastnz = z;
    n = trunc ? lastnz + 1 : 16;
    for (int z = 0; z < 16; z++) begin
      st[z].coeff = q[ord[z]];
      st[z].pos   = ord[z];
      st[z].zz    = z;
      st[z].last  = (z == n - 1);
    end
  endfunction

  task automatic check_item(input int s, input exp_t e);
    check($sformatf("dut%0d coeff zz%0d", s, e.zz), int'($signed(o_coeff_s[s])), e.coeff);
    check($sformatf("dut%0d pos zz%0d", s, e.zz), int'(o_pos_s[s]), e.pos);
    check($sformatf("dut%0d zz", s), int'(o_zz_s[s]), e.zz);
    check($sformatf("dut%0d last zz%0d", s, e.zz), int'(o_last_s[s]), int'(e.last));
  endtask

  // Scoreboards: front entry is compared every valid cycle and popped only on
  // a handshake, so a stalled output must repeat the same values.
  always @(negedge clk) begin
    exp_t st [16];
    int   n;
    if (reset) begin
      sb0.delete();
    end else begin
      if (o_valid_s[0]) begin
        if (sb0.size() == 0) check("dut0 spurious o_valid", 1, 0);
        else begin
          check_item(0, sb0[0]);
          if (o_ready_s[0]) void'(sb0.pop_front());
        end
      end
      if (i_valid_s[0] && i_ready_s[0]) begin
        model(i_data_s[0], int'(qs_s[0]), 1'b0, st, n);
        for (int z = 0; z < n; z++) sb0.push_back(st[z]);
      end
    end
  end

  always @(negedge clk) begin
    exp_t st [16];
    int   n;
    if (reset) begin
      sb1.delete();
    end else begin
      if (o_valid_s[1]) begin
        if (sb1.size() == 0) check("dut1 spurious o_valid", 1, 0);
        else begin
          check_item(1, sb1[0]);
          if (o_ready_s[1]) void'(sb1.pop_front());
        end
      end
      if (i_valid_s[1] && i_ready_s[1]) begin
        model(i_data_s[1], int'(qs_s[1]), 1'b1, st, n);
        for (int z = 0; z < n; z++) sb1.push_back(st[z]);
      end
    end
  end

  initial begin
    o_ready_s[0] = 1'b1;
    o_ready_s[1] = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      for (int s = 0; s < 2; s++) begin
        case (rdy_mode[s])
          0:       o_ready_s[s] = 1'b0;
          1:       o_ready_s[s] = 1'b1;
          default: o_ready_s[s] = 1'($urandom_range(0, 1));
        endcase
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic send_block(input int s, input logic [255:0] d, input logic [2:0] q);
    bit done = 1'b0;
    @(posedge clk);
    #1;
    i_valid_s[s] = 1'b1;
    i_data_s[s]  = d;
    qs_s[s]      = q;
    for (int t = 0; t < 300 && !done; t++) begin
      @(negedge clk);
      if (i_ready_s[s]) done = 1'b1;
      @(posedge clk);
      #1;
    end
    i_valid_s[s] = 1'b0;
    if (!done) check($sformatf("dut%0d send timeout", s), 0, 1);
  endtask

  task automatic collect(input int s, input bit chk, input int val,
                         output int cnt, output int lpos, output int lcoeff, output int lzz);
    bit done = 1'b0;
    cnt = 0; lpos = -1; lcoeff = -9999; lzz = -1;
    for (int t = 0; t < 400 && !done; t++) begin
      @(negedge clk);
      if (o_valid_s[s] && o_ready_s[s]) begin
        cnt++;
        if (chk) check($sformatf("table value zz%0d", o_zz_s[s]), int'($signed(o_coeff_s[s])), val);
        if (o_last_s[s]) begin
          done   = 1'b1;
          lpos   = int'(o_pos_s[s]);
          lcoeff = int'($signed(o_coeff_s[s]));
          lzz    = int'(o_zz_s[s]);
        end
      end
    end
    if (!done) check($sformatf("dut%0d collect timeout", s), 0, 1);
  endtask

  task automatic wait_drain(input int s);
    bit done = 1'b0;
    for (int t = 0; t < 2000 && !done; t++) begin
      @(negedge clk);
      if (!o_valid_s[s] && ((s == 0) ? sb0.size() : sb1.size()) == 0) done = 1'b1;
    end
    if (!done) check($sformatf("dut%0d drain timeout", s), 0, 1);
  endtask

  function automatic logic [255:0] rand_block(input int density);
    logic [255:0] d = '0;
    for (int p = 0; p < 16; p++) begin
      if ($urandom_range(0, 99) < density) begin
        case ($urandom_range(0, 5))
          0:       d[255-16*p -: 16] = 16'h8000;
          1:       d[255-16*p -: 16] = 16'h7FFF;
          2:       d[255-16*p -: 16] = 16'($urandom_range(0, 64)) - 16'd32;
          default: d[255-16*p -: 16] = 16'($urandom);
        endcase
      end
    end
    return d;
  endfunction

  initial begin
    vec_t         vt [15];
    logic [255:0] blk [3];
    logic [2:0]   bq [3];
    logic [255:0] d;
    int           acc [3];
    int           nacc, first, vcnt, lastv;
    int           cnt, lpos, lcoeff, lzz;
    bit           hs;

    vt[0]  = '{16'h0010, 0, 1};
    vt[1]  = '{16'h0018, 0, 2};
    vt[2]  = '{16'hFFE8, 0, -2};
    vt[3]  = '{16'h0017, 0, 1};
    vt[4]  = '{16'h8000, 0, -2048};
    vt[5]  = '{16'h7FFF, 0, 2048};
    vt[6]  = '{16'h0100, 2, 4};
    vt[7]  = '{16'h0018, 2, 0};
    vt[8]  = '{16'hFFF8, 0, -1};
    vt[9]  = '{16'h0008, 0, 1};
    vt[10] = '{16'h0007, 0, 0};
    vt[11] = '{16'hFFF9, 0, 0};
    vt[12] = '{16'h7FFF, 7, 16};
    vt[13] = '{16'h8000, 7, -16};
    vt[14] = '{16'h0040, 7, 0};

    build_order();
    reset = 1'b1;
    for (int s = 0; s < 2; s++) begin
      i_valid_s[s] = 1'b0;
      i_data_s[s]  = '0;
      qs_s[s]      = 3'd0;
    end
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    @(negedge clk);
    check("reset o_valid", int'(o_valid_s[0]), 0);
    check("reset i_ready", int'(i_ready_s[0]), 1);
    check("reset o_last", int'(o_last_s[0]), 0);
    check("reset o_coeff", int'(o_coeff_s[0]), 0);
    check("reset o_pos", int'(o_pos_s[0]), 0);
    check("reset o_zz", int'(o_zz_s[0]), 0);
    check("reset dut1 o_valid", int'(o_valid_s[1]), 0);
    check("reset dut1 i_ready", int'(i_ready_s[1]), 1);

    // Basic block: all 1.0, first valid right after acceptance
    send_block(0, {16{16'h0010}}, 3'd0);
    check("latency o_valid", int'(o_valid_s[0]), 1);
    check("latency o_zz", int'(o_zz_s[0]), 0);
    collect(0, 1'b1, 1, cnt, lpos, lcoeff, lzz);
    check("basic count", cnt, 16);
    check("basic last pos", lpos, 15);
    check("basic last zz", lzz, 15);

    // Table-driven rounding vectors
    for (int i = 0; i < 15; i++) begin
      send_block(0, {16{vt[i].c}}, 3'(vt[i].qs));
      collect(0, 1'b1, vt[i].q, cnt, lpos, lcoeff, lzz);
      check($sformatf("table%0d count", i), cnt, 16);
    end
    wait_drain(0);

    // Three back-to-back blocks, no bubbles
    for (int b = 0; b < 3; b++) begin
      blk[b] = rand_block(70);
      bq[b]  = 3'($urandom_range(0, 7));
    end
    @(posedge clk);
    #1;
    i_valid_s[0] = 1'b1;
    i_data_s[0]  = blk[0];
    qs_s[0]      = bq[0];
    nacc = 0; first = -1; vcnt = 0; lastv = -1;
    for (int t = 0; t < 120; t++) begin
      @(negedge clk);
      if (o_valid_s[0]) begin
        if (first < 0) first = t;
        vcnt++;
        lastv = t;
      end
      hs = i_valid_s[0] && i_ready_s[0];
      if (hs && nacc < 3) begin
        acc[nacc] = t;
        nacc++;
      end
      @(posedge clk);
      #1;
      if (hs) begin
        if (nacc < 3) begin
          i_data_s[0] = blk[nacc];
          qs_s[0]     = bq[nacc];
        end else begin
          i_valid_s[0] = 1'b0;
        end
      end
    end
    i_valid_s[0] = 1'b0;
    check("b2b accepted", nacc, 3);
    if (nacc == 3) begin
      check("b2b blk1 gap", acc[1] - acc[0], 1);
      check("b2b blk2 gap", acc[2] - acc[0], 17);
      check("b2b first valid", first - acc[0], 1);
    end
    check("b2b valid cycles", vcnt, 48);
    check("b2b contiguous", lastv - first + 1, 48);

    // Random blocks with random o_ready and qshift wiggling between blocks
    rdy_mode[0] = 2;
    for (int b = 0; b < 10; b++) begin
      send_block(0, rand_block($urandom_range(20, 100)), 3'($urandom_range(0, 7)));
      qs_s[0] = 3'($urandom_range(0, 7));
      repeat ($urandom_range(0, 20)) @(posedge clk);
    end
    wait_drain(0);
    rdy_mode[0] = 1;

    // End-of-block truncation
    d = '0;
    d[255-16*6 -: 16] = 16'h0040;
    send_block(1, d, 3'd0);
    collect(1, 1'b0, 0, cnt, lpos, lcoeff, lzz);
    check("eob count", cnt, 8);
    check("eob last pos", lpos, 6);
    check("eob last value", lcoeff, 4);
    check("eob last zz", lzz, 7);
    send_block(1, '0, 3'd3);
    collect(1, 1'b0, 0, cnt, lpos, lcoeff, lzz);
    check("zero blk count", cnt, 1);
    check("zero blk zz", lzz, 0);
    check("zero blk value", lcoeff, 0);

    rdy_mode[1] = 2;
    for (int b = 0; b < 10; b++) begin
      send_block(1, rand_block($urandom_range(0, 30)), 3'($urandom_range(0, 7)));
      qs_s[1] = 3'($urandom_range(0, 7));
      repeat ($urandom_range(0, 10)) @(posedge clk);
    end
    wait_drain(1);
    rdy_mode[1] = 1;

    // Reset in the middle of block 1 with block 2 buffered
    send_block(0, rand_block(100), 3'd0);
    send_block(0, rand_block(100), 3'd1);
    hs = 1'b0;
    for (int t = 0; t < 100 && !hs; t++) begin
      @(negedge clk);
      if (o_valid_s[0] && o_zz_s[0] == 4'd5) hs = 1'b1;
    end
    check("reset test reached zz5", int'(hs), 1);
    @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("post-reset o_valid", int'(o_valid_s[0]), 0);
    check("post-reset i_ready", int'(i_ready_s[0]), 1);
    repeat (3) @(negedge clk);
    check("post-reset idle", int'(o_valid_s[0]), 0);
    send_block(0, rand_block(100), 3'd2);
    check("post-reset first zz", int'(o_zz_s[0]), 0);
    check("post-reset first valid", int'(o_valid_s[0]), 1);
    wait_drain(0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/dct_quant_zigzag.md
Name: dct_quant_zigzag

Overview:
- Downstream consumer of the 4x4 DCT stage. Accepts one 256-bit block of 16 signed Q11.4 coefficients over valid/ready.
- Quantizes each coefficient by a per-block right-shift with round-half-away-from-zero.
- Emits the quantized values one per cycle in zigzag order toward the entropy coder.
- A two-slot ping-pong buffer lets the next block be captured while the current one is still streaming.

Parameters:
- TRUNC_EOB, 0: if 1, the block stream ends at the last nonzero coefficient in zigzag order (end-of-block truncation).
- OUT_W, 16: width of o_coeff. Must be at least 13.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high.
- i_valid  in  1  input block valid.
- i_ready  out  1  a buffer slot is free.
- i_data  in  256  coeff[r][c] at i_data[255-64r-16c -: 16], signed Q11.4 (1 sign, 11 integer, 4 fraction bits).
- i_qshift  in  3  quantizer shift, 0..7, sampled with i_data.
- o_valid  out  1  output coefficient valid.
- o_ready  in  1  downstream ready.
- o_coeff  out  OUT_W  quantized coefficient, signed, sign-extended.
- o_pos  out  4  raster position r*4+c of the current coefficient.
- o_zz  out  4  zigzag index 0..15.
- o_last  out  1  final coefficient of the block.

Behaviour:
- Clock and reset: clk rising edge; reset is synchronous, active-high.
- Reset values: slot-full flags = 0, wr_ptr = rd_ptr = 0, zz counter = 0, o_valid = 0, o_last = 0, o_coeff = 0, o_pos = 0, o_zz = 0; i_ready = 1 in the first cycle after reset.
- Handshakes: a transfer occurs on a clk edge where valid && ready.
- i_ready = ~full[wr_ptr]. It is a function of registered state only; there is no combinational path from o_ready.
- Capture: on input handshake, quantize all 16 coefficients and store them, plus last_nz (the highest zigzag index holding a nonzero value, 0 if the block is all zero), in slot wr_ptr. Then set full[wr_ptr] and toggle wr_ptr.
- Quantization, with k = 4 + i_qshift and m = |c| (17-bit, so -32768 is handled):
  - q = (m + 2^(k-1)) >> k, negated when c < 0.
  - Range is -2048..2048. No saturation is needed.
  - Examples: 1.5 -> 2, -1.5 -> -2, 1.4375 -> 1.
- Zigzag raster order: 0,1,4,8,5,2,3,6,9,12,13,10,7,11,14,15.
- Output from slot rd_ptr when full[rd_ptr] = 1:
  - o_valid = 1; o_zz = counter; o_pos = zigzag[counter]; o_coeff = stored value at o_pos.
  - o_last = (counter == 15) when TRUNC_EOB = 0; o_last = (counter == last_nz) when TRUNC_EOB = 1.
- Output hold: while o_valid && !o_ready, every output holds stable.
- Output advance: on output handshake, counter increments.
  - On a handshake with o_last = 1: counter returns to 0, full[rd_ptr] clears, rd_ptr toggles.
  - If the other slot is full, its zz 0 is presented the very next cycle, with no bubble.
- Latency: with both slots empty, a block accepted at edge T presents zz 0 with o_valid = 1 in the cycle after T.
- Throughput: one coefficient per cycle sustained with o_ready = 1.
- Simultaneous events:
  - Input capture into slot A and the last-coefficient handshake of slot B in the same edge both take effect.
  - With both slots full, i_ready stays 0 during the cycle of the last handshake and rises in the following cycle.
- All-zero block with TRUNC_EOB = 1: exactly one output, o_zz = 0, o_coeff = 0, o_last = 1.
- i_qshift is used only at capture time. Changing it mid-stream does not affect stored blocks.
- Reset mid-operation: all stored blocks are discarded and the block returns to reset values. No partial block is emitted afterwards.
- Interface state machine:
  - EMPTY (no slot full): o_valid = 0.
  - STREAM (rd slot full): emitting.
  - FULL (both slots full): emitting, i_ready = 0.
  - Transitions are driven only by input handshakes and last-output handshakes.

Test Plan:
- All 16 coefficients = 16'h0010, qshift 0, TRUNC_EOB 0, o_ready = 1 -> 16 outputs of value 1, o_pos sequence 0,1,4,8,5,2,3,6,9,12,13,10,7,11,14,15, o_last only with o_zz = 15, first o_valid in the cycle after acceptance.
- Rounding block, qshift 0: 16'h0018 -> 2, 16'hFFE8 -> -2, 16'h0017 -> 1, 16'h8000 -> -2048, 16'h7FFF -> 2048. Same block with qshift 2: 16'h0100 -> 4, 16'h0018 -> 0.
- Three back-to-back blocks with i_valid = 1, o_ready = 1 -> blocks 1 and 2 accepted on consecutive cycles, i_ready low until block 1 ends, 48 contiguous o_valid cycles with no bubbles, per-block values correct.
- Pseudo-random o_ready (about 50% duty) -> outputs stable across every stalled cycle, no coefficient dropped or duplicated, output matches the reference-model order.
- TRUNC_EOB = 1: only raster 6 = 16'h0040 (4.0), rest 0 -> 8 outputs (zz 0..7), last at o_pos 6 with value 4. All-zero block -> one output with value 0, o_zz 0, o_last = 1.
- Reset asserted after 5 coefficients of block 1 with block 2 buffered -> o_valid = 0 and i_ready = 1 in the cycle after reset. A new block afterwards streams from zz 0 with no remnants.
